traffic_phase_seq: RTL and testbench

- Parametrised successor to the fixed two-group intersection controller.
- Sequences N_PHASES signal phases round-robin. Each phase has its own runtime-adjustable green time; the yellow time is shared by all phases.
- Supports run, night (flashing yellow), set-green and set-yellow modes.
- Sits between the 1 s tick generator / key pulse logic and the lamp drivers / 7-seg display path.

---
 rtl/traffic_phase_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_traffic_phase_seq.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_seq.sv
// traffic_phase_seq: round-robin sequencer for N_PHASES signal phases.
// Each phase has its own runtime-editable green time. One yellow time is
// shared by all phases. Modes are run, night (flashing yellow), set-green
// and set-yellow. All outputs are registered.
//
// Optional feature: define ALLRED_EN to insert an all-red clearance stage of
// ALLRED_TICKS ticks after every yellow. The stage is skipped when
// ALLRED_TICKS is 0.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   tick       single-cycle 1 s pulse
//   mode       00 run, 01 night, 10 set-green, 11 set-yellow
//   sel_phase  phase whose green time is edited in set-green mode
//   key_plus   single-cycle increment pulse
//   key_sub    single-cycle decrement pulse
//   red        red lamp per phase
//   yellow     yellow lamp per phase
//   green      green lamp per phase
//   cur_phase  active phase index
//   stage      0 night, 1 green, 2 yellow, 3 all-red
//   remain     ticks left in the current stage (0 in night)
//   set_value  green time of sel_phase in set-green mode, yellow time otherwise
module traffic_phase_seq #(
    parameter int unsigned N_PHASES       = 4,
    parameter int unsigned CNT_WIDTH      = 11,
    parameter int unsigned GREEN_DEFAULT  = 8,
    parameter int unsigned YELLOW_DEFAULT = 6,
    parameter int unsigned ALLRED_TICKS   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick,
    input  logic [1:0]                  mode,
    input  logic [$clog2(N_PHASES)-1:0] sel_phase,
    input  logic                        key_plus,
    input  logic                        key_sub,
    output logic [N_PHASES-1:0]         red,
    output logic [N_PHASES-1:0]         yellow,
    output logic [N_PHASES-1:0]         green,
    output logic [$clog2(N_PHASES)-1:0] cur_phase,
    output logic [1:0]                  stage,
    output logic [CNT_WIDTH-1:0]        remain,
    output logic [CNT_WIDTH-1:0]        set_value
);

    localparam int unsigned SEL_W = $clog2(N_PHASES);

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_NIGHT = 2'b01;
    localparam logic [1:0] MODE_SET_G = 2'b10;
    localparam logic [1:0] MODE_SET_Y = 2'b11;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_MIN = CNT_WIDTH'(1);

`ifdef ALLRED_EN
    localparam bit ALLRED_ON = 1'b1;
`else
    localparam bit ALLRED_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_NIGHT  = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_ALLRED = 2'd3
    } stage_e;

    stage_e               stage_q, stage_d;
    logic [SEL_W-1:0]     phase_q, phase_d;
    logic [CNT_WIDTH-1:0] remain_q, remain_d;
    logic                 flash_q, flash_d;
    logic [1:0]           mode_q;
    logic [CNT_WIDTH-1:0] green_dur_q [N_PHASES];
    logic [CNT_WIDTH-1:0] green_dur_d [N_PHASES];
    logic [CNT_WIDTH-1:0] yellow_dur_q, yellow_dur_d;
    logic [N_PHASES-1:0]  red_q, red_d;
    logic [N_PHASES-1:0]  yellow_q, yellow_d;
    logic [N_PHASES-1:0]  green_q, green_d;
    logic [CNT_WIDTH-1:0] set_value_q, set_value_d;

    logic [SEL_W-1:0]     next_phase;
    logic                 tick_ok;
    logic                 sel_valid;
    logic                 key_inc;
    logic                 key_dec;

    // Saturating +/-1 adjustment of a duration, clamped to [1, 2^CNT_WIDTH-1].
    function automatic logic [CNT_WIDTH-1:0] adjust(
        input logic [CNT_WIDTH-1:0] v,
        input logic                 inc,
        input logic                 dec
    );
        logic [CNT_WIDTH-1:0] r;
        r = v;
        if (inc && (v != CNT_MAX)) begin
            r = v + CNT_WIDTH'(1);
        end else if (dec && (v > CNT_MIN)) begin
            r = v - CNT_WIDTH'(1);
        end
        return r;
    endfunction

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q      <= ST_NIGHT;
            phase_q      <= '0;
            remain_q     <= '0;
            flash_q      <= 1'b0;
            mode_q       <= MODE_NIGHT;
            for (int unsigned i = 0; i < N_PHASES; i++) begin
                green_dur_q[i] <= CNT_WIDTH'(GREEN_DEFAULT);
            end
            yellow_dur_q <= CNT_WIDTH'(YELLOW_DEFAULT);
            red_q        <= '0;
            yellow_q     <= '0;
            green_q      <= '0;
            set_value_q  <= CNT_WIDTH'(YELLOW_DEFAULT);
        end else begin
            stage_q      <= stage_d;
            phase_q      <= phase_d;
            remain_q     <= remain_d;
            flash_q      <= flash_d;
            mode_q       <= mode;
            green_dur_q  <= green_dur_d;
            yellow_dur_q <= yellow_dur_d;
            red_q        <= red_d;
            yellow_q     <= yellow_d;
            green_q      <= green_d;
            set_value_q  <= set_value_d;
        end
    end

    // Next-state, duration edits and lamp decode.
    always_comb begin
        stage_d      = stage_q;
        phase_d      = phase_q;
        remain_d     = remain_q;
        flash_d      = flash_q;
        green_dur_d  = green_dur_q;
        yellow_dur_d = yellow_dur_q;
        red_d        = '0;
        yellow_d     = '0;
        green_d      = '0;
        set_value_d  = '0;

        next_phase = (phase_q == SEL_W'(N_PHASES - 1)) ? '0 : phase_q + SEL_W'(1);
        // A tick arriving together with a mode change is dropped.
        tick_ok    = tick && (mode == mode_q);
        sel_valid  = (32'(sel_phase) < N_PHASES);
        key_inc    = key_plus && !key_sub;
        key_dec    = key_sub && !key_plus;

        // Duration editing; only the stored durations change, never remain.
        if ((mode == MODE_SET_G) && sel_valid) begin
            green_dur_d[sel_phase] = adjust(green_dur_q[sel_phase], key_inc, key_dec);
        end
        if (mode == MODE_SET_Y) begin
            yellow_dur_d = adjust(yellow_dur_q, key_inc, key_dec);
        end

        // Sequencer: night has priority, set modes freeze everything but flash.
        if (mode == MODE_NIGHT) begin
            if (stage_q != ST_NIGHT) begin
                stage_d  = ST_NIGHT;
                remain_d = '0;
                flash_d  = 1'b0;
            end else if (tick_ok) begin
                flash_d = !flash_q;
            end
        end else if (stage_q == ST_NIGHT) begin
            if (mode == MODE_RUN) begin
                stage_d  = ST_GREEN;
                phase_d  = '0;
                remain_d = green_dur_q[0];
                flash_d  = 1'b0;
            end else if (tick_ok) begin
                flash_d = !flash_q;
            end
        end else if ((mode == MODE_RUN) && tick_ok) begin
            if (remain_q > CNT_WIDTH'(1)) begin
                remain_d = remain_q - CNT_WIDTH'(1);
            end else begin
                // Last tick of the stage: advance and load the new duration.
                case (stage_q)
                    ST_GREEN: begin
                        stage_d  = ST_YELLOW;
                        remain_d = yellow_dur_q;
                    end
                    ST_YELLOW: begin
                        if (ALLRED_ON && (ALLRED_TICKS != 0)) begin
                            stage_d  = ST_ALLRED;
                            remain_d = CNT_WIDTH'(ALLRED_TICKS);
                        end else begin
                            stage_d  = ST_GREEN;
                            phase_d  = next_phase;
                            remain_d = green_dur_q[next_phase];
                        end
                    end
                    default: begin
                        stage_d  = ST_GREEN;
                        phase_d  = next_phase;
                        remain_d = green_dur_q[next_phase];
                    end
                endcase
            end
        end

        // Lamps follow the next state so they line up with stage/remain.
        for (int unsigned i = 0; i < N_PHASES; i++) begin
            if (stage_d == ST_NIGHT) begin
                yellow_d[i] = flash_d;
            end else if (SEL_W'(i) == phase_d) begin
                green_d[i]  = (stage_d == ST_GREEN);
                yellow_d[i] = (stage_d == ST_YELLOW);
                red_d[i]    = (stage_d == ST_ALLRED);
            end else begin
                red_d[i] = 1'b1;
            end
        end

        if (mode == MODE_SET_G) begin
            set_value_d = sel_valid ? green_dur_d[sel_phase] : '0;
        end else begin
            set_value_d = yellow_dur_d;
        end
    end

    assign red       = red_q;
    assign yellow    = yellow_q;
    assign green     = green_q;
    assign cur_phase = phase_q;
    assign stage     = stage_q;
    assign remain    = remain_q;
    assign set_value = set_value_q;

endmodule

// File: tb/tb_traffic_phase_seq.sv
// Bench for traffic_phase_seq: directed scenarios plus randomized stimulus,
// checked every cycle against a behavioural model of the phase sequence.
module tb_traffic_phase_seq;

    localparam int N    = 4;
    localparam int CW   = 11;
    localparam int GD   = 8;
    localparam int YD   = 6;
    localparam int AT   = 2;
    localparam int MAXV = (1 << CW) - 1;
`ifdef ALLRED_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    localparam int PER = GD + YD + ((AR && AT > 0) ? AT : 0);

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic [1:0]    mode;
    logic [1:0]    sel_phase;
    logic          key_plus;
    logic          key_sub;
    logic [N-1:0]  red;
    logic [N-1:0]  yellow;
    logic [N-1:0]  green;
    logic [1:0]    cur_phase;
    logic [1:0]    stage;
    logic [CW-1:0] remain;
    logic [CW-1:0] set_value;

    int errors = 0;
    int checks = 0;

    traffic_phase_seq dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .mode      (mode),
        .sel_phase (sel_phase),
        .key_plus  (key_plus),
        .key_sub   (key_sub),
        .red       (red),
        .yellow    (yellow),
        .green     (green),
        .cur_phase (cur_phase),
        .stage     (stage),
        .remain    (remain),
        .set_value (set_value)
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    int         m_stage;
    int         m_phase;
    int         m_remain;
    bit         m_flash;
    int         m_g [N];
    int         m_y;
    logic [1:0] m_prev;
    int         m_setv;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        if (v < 1) return 1;
        if (v > MAXV) return MAXV;
        return v;
    endfunction

    task automatic next_green();
        m_phase  = (m_phase + 1) % N;
        m_stage  = 1;
        m_remain = m_g[m_phase];
    endtask

    task automatic model_step();
        bit tk_ok;
        int step;
        if (rst) begin
            m_stage = 0; m_phase = 0; m_remain = 0; m_flash = 0;
            for (int i = 0; i < N; i++) m_g[i] = GD;
            m_y = YD; m_prev = 2'b01; m_setv = YD;
        end else begin
            tk_ok = tick && (mode == m_prev);
            step  = (key_plus && !key_sub) ? 1 : ((key_sub && !key_plus) ? -1 : 0);
            if (mode == 2'b10 && int'(sel_phase) < N) m_g[sel_phase] = clamp(m_g[sel_phase] + step);
            if (mode == 2'b11) m_y = clamp(m_y + step);
            if (mode == 2'b01) begin
                if (m_stage != 0) begin
                    m_stage = 0; m_remain = 0; m_flash = 0;
                end else if (tk_ok) m_flash = !m_flash;
            end else if (m_stage == 0) begin
                if (mode == 2'b00) begin
                    m_stage = 1; m_phase = 0; m_remain = m_g[0]; m_flash = 0;
                end else if (tk_ok) m_flash = !m_flash;
            end else if (mode == 2'b00 && tk_ok) begin
                if (m_remain > 1) m_remain--;
                else if (m_stage == 1) begin
                    m_stage = 2; m_remain = m_y;
                end else if (m_stage == 2 && AR && AT > 0) begin
                    m_stage = 3; m_remain = AT;
                end else next_green();
            end
            m_setv = (mode == 2'b10) ? ((int'(sel_phase) < N) ? m_g[sel_phase] : 0) : m_y;
            m_prev = mode;
        end
    endtask

    function automatic void exp_lamps(output int r, output int y, output int g);
        r = 0; y = 0; g = 0;
        for (int i = 0; i < N; i++) begin
            if (m_stage == 0) begin
                if (m_flash) y |= (1 << i);
            end else if (i == m_phase) begin
                if (m_stage == 1) g |= (1 << i);
                if (m_stage == 2) y |= (1 << i);
                if (m_stage == 3) r |= (1 << i);
            end else r |= (1 << i);
        end
    endfunction

    // Model update at each edge, compare shortly after.
    initial begin
        int er, ey, eg;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            exp_lamps(er, ey, eg);
            chk("red", int'(red), er);
            chk("yellow", int'(yellow), ey);
            chk("green", int'(green), eg);
            chk("cur_phase", int'(cur_phase), m_phase);
            chk("stage", int'(stage), m_stage);
            chk("remain", int'(remain), m_remain);
            chk("set_value", int'(set_value), m_setv);
        end
    end

    task automatic cyc(input bit t, input bit p, input bit s);
        tick = t; key_plus = p; key_sub = s;
        @(negedge clk);
        tick = 1'b0; key_plus = 1'b0; key_sub = 1'b0;
    endtask

    task automatic tk();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    // Runs to the start of phase ph's green, then counts its length in ticks.
    task automatic measure_green(input int ph, output int n);
        int b;
        b = 0;
        while (!(stage == 2'd1 && int'(cur_phase) == ph) && b < 500) begin
            tk();
            b++;
        end
        chk("reach_green", int'(stage == 2'd1 && int'(cur_phase) == ph), 1);
        n = 0;
        while (stage == 2'd1 && n < 5000) begin
            tk();
            n++;
        end
    endtask

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int b;
        int ph;
        rst = 1'b1; tick = 1'b0; mode = 2'b01; sel_phase = '0;
        key_plus = 1'b0; key_sub = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 0);
        chk("rst_stage", int'(stage), 0);
        chk("rst_remain", int'(remain), 0);
        chk("rst_lamps", int'({red, yellow, green}), 0);
        chk("rst_phase", int'(cur_phase), 0);

        // Run from defaults.
        mode = 2'b00;
        cyc(0, 0, 0);
        chk("run_green0", int'(green), 4'b0001);
        chk("run_red0", int'(red), 4'b1110);
        chk("run_remain0", int'(remain), 8);
        repeat (7) tk();
        chk("run_remain1", int'(remain), 1);
        tk();
        chk("run_yellow0", int'(yellow), 4'b0001);
        chk("run_yremain", int'(remain), 6);
        repeat (6) tk();
`ifdef ALLRED_EN
        chk("allred_stage", int'(stage), 3);
        chk("allred_red", int'(red), 4'b1111);
        chk("allred_remain", int'(remain), 2);
        repeat (2) tk();
`endif
        chk("run_green1", int'(green), 4'b0010);
        chk("run_phase1", int'(cur_phase), 1);
        chk("run_remain_g1", int'(remain), 8);
        repeat ((N - 1) * PER) tk();
        chk("wrap_phase", int'(cur_phase), 0);
        chk("wrap_green", int'(green), 4'b0001);
        chk("wrap_remain", int'(remain), 8);

        // Night mid-green.
        repeat (3) tk();
        mode = 2'b01;
        cyc(0, 0, 0);
        chk("night_stage", int'(stage), 0);
        chk("night_remain", int'(remain), 0);
        chk("night_rg", int'({red, green}), 0);
        chk("night_y0", int'(yellow), 0);
        tk();
        chk("night_y1", int'(yellow), 4'b1111);
        tk();
        chk("night_y2", int'(yellow), 4'b0000);
        mode = 2'b00;
        cyc(0, 0, 0);
        chk("night_exit_green", int'(green), 4'b0001);
        chk("night_exit_remain", int'(remain), 8);

        // Set-green on phase 2.
        mode = 2'b10; sel_phase = 2'd2;
        cyc(0, 0, 0);
        chk("setg_init", int'(set_value), 8);
        repeat (3) cyc(0, 1, 0);
        chk("setg_plus3", int'(set_value), 11);
        cyc(0, 1, 1);
        chk("setg_both", int'(set_value), 11);
        chk("setg_frozen", int'(remain), 8);
        mode = 2'b00;
        cyc(0, 0, 0);
        measure_green(2, n);
        chk("green2_len", n, 11);
        measure_green(3, n);
        chk("green3_len", n, 8);

        // Set-yellow saturation.
        mode = 2'b11;
        cyc(0, 0, 0);
        chk("sety_init", int'(set_value), 6);
        repeat (5) cyc(0, 0, 1);
        chk("sety_min", int'(set_value), 1);
        cyc(0, 0, 1);
        chk("sety_min_sat", int'(set_value), 1);
        repeat (MAXV - 1) cyc(0, 1, 0);
        chk("sety_max", int'(set_value), MAXV);
        cyc(0, 1, 0);
        chk("sety_max_sat", int'(set_value), MAXV);
        repeat (MAXV - YD) cyc(0, 0, 1);
        chk("sety_restore", int'(set_value), YD);

        // Freeze: hold at remain=5 for 20 ticks in set-green.
        mode = 2'b00;
        cyc(0, 0, 0);
        b = 0;
        while (!(stage == 2'd1 && remain == CW'(5)) && b < 500) begin
            tk();
            b++;
        end
        chk("freeze_reach", int'(stage == 2'd1 && remain == CW'(5)), 1);
        ph = m_phase;
        mode = 2'b10;
        cyc(0, 0, 0);
        repeat (20) tk();
        chk("freeze_remain", int'(remain), 5);
        chk("freeze_stage", int'(stage), 1);
        chk("freeze_green", int'(green), 1 << ph);
        mode = 2'b00;
        cyc(0, 0, 0);
        n = 0;
        while (stage == 2'd1 && n < 100) begin
            tk();
            n++;
        end
        chk("freeze_resume", n, 5);

        // Randomized run.
        for (int c = 0; c < 4000; c++) begin
            int r;
            if ($urandom_range(0, 19) == 0) begin
                r = $urandom_range(0, 99);
                mode = (r < 70) ? 2'b00 : (r < 78) ? 2'b01 : (r < 89) ? 2'b10 : 2'b11;
            end
            sel_phase = 2'($urandom_range(0, 3));
            tick      = ($urandom_range(0, 9) < 3);
            key_plus  = ($urandom_range(0, 9) == 0);
            key_sub   = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 799) == 0);
            @(negedge clk);
        end
        rst = 1'b0; tick = 1'b0; key_plus = 1'b0; key_sub = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
